frame_bank_sched: RTL and testbench
===================================

# frame_bank_sched

Triple-buffer bank scheduler for the video frame store, clocked in the pixel domain. It owns the three frame banks in external memory and decides which bank the frame writer fills and which bank the display reader scans. It answers the display generator's per-frame `read_req`/`read_req_ack` handshake by handing out the newest completed frame. Each side gets a registered bank index and base address, and the block counts dropped and repeated frames.

## Interface
- `ADDR_WIDTH`, default 24: memory word-address width.
- `BASE_ADDR`, default 0: word address of bank 0.
- `FRAME_WORDS`, default 1024*768: words per bank; bank k base = `BASE_ADDR + k*FRAME_WORDS`.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `video_clk`  in  1  pixel clock; all ports synchronous to it.
- `rst`  in  1  reset, asynchronous, active-high.
- `read_req`  in  1  display wants the next frame; level, held until ack seen.
- `read_req_ack`  out  1  one-cycle acknowledge; `read_bank`/`read_base_addr` valid from this cycle.
- `read_bank`  out  2  bank the reader scans (0..2).
- `read_base_addr`  out  ADDR_WIDTH  base of `read_bank`.
- `write_done`  in  1  one-cycle pulse: writer finished filling `write_bank`. Synchronized to `video_clk` upstream.
- `write_bank`  out  2  bank the writer fills (0..2).
- `write_base_addr`  out  ADDR_WIDTH  base of `write_bank`.
- `frame_fresh`  out  1  a completed frame is waiting that the reader has not yet taken.
- `drop_cnt`  out  CNT_WIDTH  completed frames overwritten before being read; saturating.
- `repeat_cnt`  out  CNT_WIDTH  read requests served with no fresh frame; saturating.

## Operation
- State:
  - three 2-bit indices `rd`, `lat` (latest completed), `wr`, always a permutation of {0,1,2};
  - flag `fresh`.
- Reset values:
  - `rd=0`, `lat=1`, `wr=2`, `fresh=0`;
  - `read_req_ack=0`;
  - both counters 0;
  - base addresses equal to the bases of banks 0 and 2.
- Write completion (`write_done=1`):
  - swap `wr` and `lat`, then set `fresh=1`;
  - if `fresh` was already 1, increment `drop_cnt`.
- Read service fires when `read_req=1 && read_req_ack=0`:
  - next cycle `read_req_ack=1` for exactly one cycle;
  - if `fresh` (post-write value, see below), swap `rd` and `lat` and set `fresh=0`;
  - otherwise `rd` is unchanged and `repeat_cnt` increments.
- Simultaneous `write_done` and a read service in the same cycle:
  - the write update is applied first; the reader then takes the just-completed frame;
  - net result: new `rd` = old `wr`, new `wr` = old `lat`, new `lat` = old `rd`, `fresh=0`;
  - `drop_cnt` still increments if old `fresh` was 1; `repeat_cnt` does not change.
- `rd` and `wr` are never equal; the writer never touches the bank being displayed.
- Counters saturate at all-ones and never wrap.
- Base address = `BASE_ADDR + index*FRAME_WORDS`, computed with mux/add (no multiplier), registered in the same cycle as the index.

## Timing
- Request handshake:
  - `read_req` sampled high at edge N → `read_req_ack`, `read_bank`, `read_base_addr` updated at edge N+1.
  - The requester drops `read_req` at edge N+2.
  - Because `read_req` is still high in cycle N+1 while ack is high, the `!read_req_ack` term prevents a double service.
- `write_bank`/`write_base_addr` change at the edge after the `write_done` cycle. The writer starts its next frame no earlier than that.
- `frame_fresh` and the counters are registered and update with the same edge as the indices.
- Reset asserted mid-frame restores all reset values immediately. Any pending `read_req` is serviced normally after release.

## Structure
- Shared include file holds:
  - the bank-count constant (3);
  - the reset index assignment (`RD0=0`, `LAT0=1`, `WR0=2`);
  - the `BANK_W=2` width.
- One sub-module, `bank_base_calc`: combinational index→address mapping using parameters `BASE_ADDR` and `FRAME_WORDS`. Instantiated twice (read and write); outputs registered in the parent.
- Target size: about 150 RTL lines.

## Test plan
- Reset then idle:
  - `read_bank=0`, `write_bank=2`, `write_base_addr=2*FRAME_WORDS`, `read_req_ack=0`, `frame_fresh=0`.
- One `write_done`, then `read_req` held until ack:
  - exactly one ack pulse one cycle after req;
  - `read_bank=2`, `write_bank=1`, `frame_fresh=0`, both counters 0.
- Two `write_done` pulses, then one read:
  - `drop_cnt=1`, `read_bank` equals the bank written second;
  - `rd`≠`wr` checked every cycle.
- Read with no write:
  - `read_bank` unchanged, `repeat_cnt` increments by 1 per request, ack still pulses.
- `write_done` in the same cycle as a read service, starting from reset:
  - `read_bank=2`, `write_bank=1`, `lat=0`, `fresh=0`.
- Force counters to max-1 and drive 3 more events:
  - each counter saturates at all-ones;
  - `rst` pulse mid-sequence restores all reset values.

Source files
------------

// File: rtl/frame_bank_sched_pkg.sv
// frame_bank_sched_pkg: bank count, index width and reset bank assignment
// shared by the triple-buffer scheduler files.
package frame_bank_sched_pkg;
   localparam int BANKS  = 3;
   localparam int BANK_W = 2;
   typedef logic [BANK_W-1:0] bank_t;
   localparam bank_t RD0  = 2'd0;
   localparam bank_t LAT0 = 2'd1;
   localparam bank_t WR0  = 2'd2;
endpackage

// File: rtl/frame_bank_sched_if.sv
// frame_bank_sched_if: display read handshake, writer completion and
// bank/address/statistics outputs of the triple-buffer scheduler.
interface frame_bank_sched_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int CNT_WIDTH  = 16
);
   import frame_bank_sched_pkg::*;
   logic                  read_req;
   logic                  read_req_ack;
   bank_t                 read_bank;
   logic [ADDR_WIDTH-1:0] read_base_addr;
   logic                  write_done;
   bank_t                 write_bank;
   logic [ADDR_WIDTH-1:0] write_base_addr;
   logic                  frame_fresh;
   logic [CNT_WIDTH-1:0]  drop_cnt;
   logic [CNT_WIDTH-1:0]  repeat_cnt;
   modport master (
      output read_req, write_done,
      input  read_req_ack, read_bank, read_base_addr, write_bank,
             write_base_addr, frame_fresh, drop_cnt, repeat_cnt
   );
   modport slave (
      input  read_req, write_done,
      output read_req_ack, read_bank, read_base_addr, write_bank,
             write_base_addr, frame_fresh, drop_cnt, repeat_cnt
   );
endinterface

// File: rtl/frame_bank_sched_bank_base_calc.sv
// bank_base_calc: combinational bank index to memory base address; constant
// per-bank bases selected by mux so no multiplier is built.
module bank_base_calc
   import frame_bank_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 24,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 1024*768
) (
   input  bank_t                 i_bank,
   output logic [ADDR_WIDTH-1:0] o_base
);
   localparam logic [ADDR_WIDTH-1:0] B0 = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] B1 = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);
   localparam logic [ADDR_WIDTH-1:0] B2 = ADDR_WIDTH'(BASE_ADDR + 2*FRAME_WORDS);

   assign o_base = (i_bank == bank_t'(BANKS-1)) ? B2 : (i_bank == 2'd1) ? B1 : B0;
endmodule

// File: rtl/frame_bank_sched.sv
// frame_bank_sched: triple-buffer bank scheduler; hands the newest completed
// frame to the display on request and counts dropped and repeated frames.
module frame_bank_sched
   import frame_bank_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 24,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 1024*768,
   parameter int CNT_WIDTH   = 16
) (
   input logic               video_clk,
   input logic               rst,
   frame_bank_sched_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] RST_RD_BASE = ADDR_WIDTH'(BASE_ADDR + int'(RD0)*FRAME_WORDS);
   localparam logic [ADDR_WIDTH-1:0] RST_WR_BASE = ADDR_WIDTH'(BASE_ADDR + int'(WR0)*FRAME_WORDS);

   bank_t                 r_rd, r_lat, r_wr;
   logic                  r_fresh, r_ack;
   logic [ADDR_WIDTH-1:0] r_rd_base, r_wr_base;
   logic [CNT_WIDTH-1:0]  r_drop, r_repeat;

   bank_t                 w_wr1, w_lat1, w_rd_n, w_lat_n;
   logic                  w_fresh1, w_svc, w_take;
   logic [ADDR_WIDTH-1:0] w_rd_base, w_wr_base;

   // The write swap is applied first so a same-cycle read takes the frame just completed.
   always_comb begin
      w_wr1    = bus.write_done ? r_lat : r_wr;
      w_lat1   = bus.write_done ? r_wr : r_lat;
      w_fresh1 = bus.write_done | r_fresh;
      w_svc    = bus.read_req & ~r_ack;
      w_take   = w_svc & w_fresh1;
      w_rd_n   = w_take ? w_lat1 : r_rd;
      w_lat_n  = w_take ? r_rd : w_lat1;
   end

   bank_base_calc #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS))
      u_rd_base (.i_bank(w_rd_n), .o_base(w_rd_base));
   bank_base_calc #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS))
      u_wr_base (.i_bank(w_wr1), .o_base(w_wr_base));

   always_ff @(posedge video_clk or posedge rst) begin
      if (rst) begin
         r_rd      <= RD0;
         r_lat     <= LAT0;
         r_wr      <= WR0;
         r_fresh   <= 1'b0;
         r_ack     <= 1'b0;
         r_rd_base <= RST_RD_BASE;
         r_wr_base <= RST_WR_BASE;
         r_drop    <= '0;
         r_repeat  <= '0;
      end else begin
         r_rd      <= w_rd_n;
         r_lat     <= w_lat_n;
         r_wr      <= w_wr1;
         r_fresh   <= w_fresh1 & ~w_take;
         r_ack     <= w_svc;
         r_rd_base <= w_rd_base;
         r_wr_base <= w_wr_base;
         if (bus.write_done && r_fresh && !(&r_drop))
            r_drop <= r_drop + CNT_WIDTH'(1);
         if (w_svc && !w_fresh1 && !(&r_repeat))
            r_repeat <= r_repeat + CNT_WIDTH'(1);
      end
   end

   assign bus.read_req_ack    = r_ack;
   assign bus.read_bank       = r_rd;
   assign bus.read_base_addr  = r_rd_base;
   assign bus.write_bank      = r_wr;
   assign bus.write_base_addr = r_wr_base;
   assign bus.frame_fresh     = r_fresh;
   assign bus.drop_cnt        = r_drop;
   assign bus.repeat_cnt      = r_repeat;
endmodule

// File: tb/tb_frame_bank_sched.sv
// tb_frame_bank_sched: directed vector table plus hand sequences for the
// triple-buffer scheduler, with 2-bit counters so saturation is reachable.
module tb_frame_bank_sched;
   localparam int AW = 16, BASE = 16, FW = 100, CW = 2;

   logic video_clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0, n_err = 0;

   always #5 video_clk = ~video_clk;

   frame_bank_sched_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
   frame_bank_sched #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_WORDS(FW), .CNT_WIDTH(CW))
      dut (.video_clk(video_clk), .rst(rst), .bus(bus));

   typedef struct {
      logic       req, wd;
      logic [1:0] rb, wb;
      logic       ack, fr;
      logic [1:0] d, r;
   } vec_t;

   vec_t v[24];

   task automatic tick();
      @(posedge video_clk);
      #1;
   endtask

   task automatic chk(string name, int idx, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s[%0d] got %0d want %0d", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(string tag, int idx, logic [1:0] rb, logic [1:0] wb,
                          logic ack, logic fr, logic [1:0] d, logic [1:0] r);
      chk({tag, "_read_bank"}, idx, int'(bus.read_bank), int'(rb));
      chk({tag, "_write_bank"}, idx, int'(bus.write_bank), int'(wb));
      chk({tag, "_read_base"}, idx, int'(bus.read_base_addr), BASE + FW*int'(rb));
      chk({tag, "_write_base"}, idx, int'(bus.write_base_addr), BASE + FW*int'(wb));
      chk({tag, "_ack"}, idx, int'(bus.read_req_ack), int'(ack));
      chk({tag, "_fresh"}, idx, int'(bus.frame_fresh), int'(fr));
      chk({tag, "_drop"}, idx, int'(bus.drop_cnt), int'(d));
      chk({tag, "_repeat"}, idx, int'(bus.repeat_cnt), int'(r));
   endtask

   // Reader and writer must never share a bank, checked every cycle out of reset.
   always @(negedge video_clk) begin
      if (!rst) begin
         n_vec++;
         if (bus.read_bank == bus.write_bank || bus.read_bank > 2'd2 || bus.write_bank > 2'd2) begin
            n_err++;
            $display("FAIL rd_ne_wr at %0t got rd=%0d wr=%0d", $time, bus.read_bank, bus.write_bank);
         end
      end
   end

   initial begin
      //          req  wd   rb wb ack fr d  r
      v[0]  = '{1'b0, 1'b0, 0, 2, 0, 0, 0, 0};
      v[1]  = '{1'b0, 1'b1, 0, 1, 0, 1, 0, 0};
      v[2]  = '{1'b1, 1'b0, 2, 1, 1, 0, 0, 0};
      v[3]  = '{1'b1, 1'b0, 2, 1, 0, 0, 0, 0};
      v[4]  = '{1'b0, 1'b0, 2, 1, 0, 0, 0, 0};
      v[5]  = '{1'b0, 1'b1, 2, 0, 0, 1, 0, 0};
      v[6]  = '{1'b0, 1'b1, 2, 1, 0, 1, 1, 0};
      v[7]  = '{1'b1, 1'b0, 0, 1, 1, 0, 1, 0};
      v[8]  = '{1'b0, 1'b0, 0, 1, 0, 0, 1, 0};
      v[9]  = '{1'b1, 1'b0, 0, 1, 1, 0, 1, 1};
      v[10] = '{1'b1, 1'b0, 0, 1, 0, 0, 1, 1};
      v[11] = '{1'b1, 1'b0, 0, 1, 1, 0, 1, 2};
      v[12] = '{1'b0, 1'b0, 0, 1, 0, 0, 1, 2};
      v[13] = '{1'b1, 1'b1, 1, 2, 1, 0, 1, 2};
      v[14] = '{1'b0, 1'b0, 1, 2, 0, 0, 1, 2};
      v[15] = '{1'b1, 1'b0, 1, 2, 1, 0, 1, 3};
      v[16] = '{1'b0, 1'b0, 1, 2, 0, 0, 1, 3};
      v[17] = '{1'b1, 1'b0, 1, 2, 1, 0, 1, 3};
      v[18] = '{1'b0, 1'b0, 1, 2, 0, 0, 1, 3};
      v[19] = '{1'b0, 1'b1, 1, 0, 0, 1, 1, 3};
      v[20] = '{1'b0, 1'b1, 1, 2, 0, 1, 2, 3};
      v[21] = '{1'b0, 1'b1, 1, 0, 0, 1, 3, 3};
      v[22] = '{1'b0, 1'b1, 1, 2, 0, 1, 3, 3};
      v[23] = '{1'b0, 1'b0, 1, 2, 0, 1, 3, 3};

      bus.read_req   = 1'b0;
      bus.write_done = 1'b0;
      #23 rst = 1'b0;
      #1 chk_all("reset", 0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0);

      for (int i = 0; i < 24; i++) begin
         bus.read_req   = v[i].req;
         bus.write_done = v[i].wd;
         tick();
         chk_all("vec", i, v[i].rb, v[i].wb, v[i].ack, v[i].fr, v[i].d, v[i].r);
      end
      bus.read_req   = 1'b0;
      bus.write_done = 1'b0;

      // Same-cycle write completion and read service straight out of reset.
      tick();
      #1 rst = 1'b1;
      #1 chk_all("rst_a", 0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0);
      #1 rst = 1'b0;
      bus.read_req   = 1'b1;
      bus.write_done = 1'b1;
      tick();
      chk_all("simul", 0, 2'd2, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0);
      chk("simul_lat", 0, 3 - int'(bus.read_bank) - int'(bus.write_bank), 0);
      bus.read_req   = 1'b0;
      bus.write_done = 1'b0;
      tick();
      chk_all("simul_after", 0, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0);

      // Reset mid-sequence with a request pending, then service after release.
      bus.write_done = 1'b1;
      tick();
      tick();
      chk("pre_rst_drop", 0, int'(bus.drop_cnt), 1);
      bus.write_done = 1'b0;
      bus.read_req   = 1'b1;
      #1 rst = 1'b1;
      #1 chk_all("rst_b", 0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0);
      #1 rst = 1'b0;
      tick();
      chk_all("post_rst", 0, 2'd0, 2'd2, 1'b1, 1'b0, 2'd0, 2'd1);
      tick();
      chk_all("post_rst", 1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd1);
      bus.read_req = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
